// File: rtl/cpc_clk_pkg.sv
// Shared constants for the CPC clock-enable generator: default counter width,
// channel indices and standard divide values for a 32 MHz master clock.
package cpc_clk_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    CH_PIX16 = 2'd0,
    CH_CCLK  = 2'd1,
    CH_PHI   = 2'd2,
    CH_AUX   = 2'd3
  } cpc_ch_e;

  localparam int NUM_STD_CH = 4;

  // Divide values are ratio minus one, relative to a 32 MHz clk.
  localparam logic [CNT_W_DEF-1:0] DIV_16M = 8'd1;
  localparam logic [CNT_W_DEF-1:0] DIV_8M  = 8'd3;
  localparam logic [CNT_W_DEF-1:0] DIV_4M  = 8'd7;
  localparam logic [CNT_W_DEF-1:0] DIV_1M  = 8'd31;

endpackage

// File: rtl/cpc_cen_chan.sv
// One clock-enable channel: programmable ratio counter with phase load,
// registered rising/falling enable pulses and a level virtual clock.
module cpc_cen_chan
  import cpc_clk_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic [CNT_W-1:0] div_i,
  input  logic [CNT_W-1:0] phase_i,
  output logic             cen_p_o,
  output logic             cen_n_o,
  output logic             clk_o,
  output logic             at_zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic             cen_p_q, cen_p_d;
  logic             cen_n_q, cen_n_d;
  logic             clk_q, clk_d;
  logic [CNT_W:0]   half;
  logic [CNT_W-1:0] load_val;

  // One extra bit so an all-ones divide does not wrap to zero.
  assign half     = ({1'b0, cur_div_q} + 1'b1) >> 1;
  assign load_val = (phase_i <= div_i) ? phase_i : '0;

  always_comb begin
    cnt_d     = cnt_q;
    cur_div_d = cur_div_q;
    cen_p_d   = 1'b0;
    cen_n_d   = 1'b0;
    clk_d     = clk_q;
    if (sync) begin
      cnt_d     = load_val;
      cur_div_d = div_i;
      clk_d     = 1'b0;
    end else if (en) begin
      cen_p_d = (cnt_q == '0);
      cen_n_d = ({1'b0, cnt_q} == half);
      clk_d   = ({1'b0, cnt_q} < half);
      // New ratio is picked up only at the wrap so a period never tears.
      if (cnt_q >= cur_div_q) begin
        cnt_d     = '0;
        cur_div_d = div_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= load_val;
      cur_div_q <= div_i;
      cen_p_q   <= 1'b0;
      cen_n_q   <= 1'b0;
      clk_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      cen_p_q   <= cen_p_d;
      cen_n_q   <= cen_n_d;
      clk_q     <= clk_d;
    end
  end

  assign cen_p_o   = cen_p_q;
  assign cen_n_o   = cen_n_q;
  assign clk_o     = clk_q;
  assign at_zero_o = (cnt_q == '0);

endmodule

// File: rtl/cpc_cen_gen.sv
// Multi-channel clock-enable generator: slices the per-channel buses, runs one
// cpc_cen_chan per channel and flags cycles where all channels start together.
module cpc_cen_gen
  import cpc_clk_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      sync,
  input  logic [CHANNELS*CNT_W-1:0] div,
  input  logic [CHANNELS*CNT_W-1:0] phase,
  output logic [CHANNELS-1:0]       cen_p,
  output logic [CHANNELS-1:0]       cen_n,
  output logic [CHANNELS-1:0]       clk_o,
  output logic                      aligned
);

  logic [CHANNELS-1:0] at_zero;
  logic                aligned_q, aligned_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    cpc_cen_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .sync      (sync),
      .div_i     (div[i*CNT_W +: CNT_W]),
      .phase_i   (phase[i*CNT_W +: CNT_W]),
      .cen_p_o   (cen_p[i]),
      .cen_n_o   (cen_n[i]),
      .clk_o     (clk_o[i]),
      .at_zero_o (at_zero[i])
    );
  end

  assign aligned_d = ~sync & en & (&at_zero);

  always_ff @(posedge clk) begin
    if (reset) begin
      aligned_q <= 1'b0;
    end else begin
      aligned_q <= aligned_d;
    end
  end

  assign aligned = aligned_q;

endmodule

// File: tb/tb_cpc_cen_gen.sv
// Bench for cpc_cen_gen: directed scenarios with hand-derived pulse cycles,
// then randomized control/ratio traffic against a period-position model.
module tb_cpc_cen_gen;

  localparam int CH = 2;
  localparam int W  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b1;
  logic              sync = 1'b0;
  logic [CH*W-1:0]   div = '0;
  logic [CH*W-1:0]   phase = '0;
  logic [CH-1:0]     cen_p, cen_n, clk_o;
  logic              aligned;

  int vectors = 0;
  int miscompares = 0;

  // Model: each channel is a position inside a period of R = div+1 clocks.
  int            m_pos [CH];
  int            m_per [CH];
  logic [CH-1:0] e_p, e_n, e_clk;
  logic          e_al;

  cpc_cen_gen #(.CHANNELS(CH), .CNT_W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .sync    (sync),
    .div     (div),
    .phase   (phase),
    .cen_p   (cen_p),
    .cen_n   (cen_n),
    .clk_o   (clk_o),
    .aligned (aligned)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_div(input int ch, input int v);
    div[ch*W +: W] = W'(v);
  endtask

  task automatic set_ph(input int ch, input int v);
    phase[ch*W +: W] = W'(v);
  endtask

  task automatic model_step();
    int r, p, hi;
    logic all_start;
    if (reset || sync) begin
      for (int c = 0; c < CH; c++) begin
        r = int'(div[c*W +: W]) + 1;
        p = int'(phase[c*W +: W]);
        m_per[c] = r;
        m_pos[c] = (p < r) ? p : 0;
      end
      e_p = '0; e_n = '0; e_clk = '0; e_al = 1'b0;
    end else if (en) begin
      all_start = 1'b1;
      for (int c = 0; c < CH; c++) begin
        hi = m_per[c] / 2;
        e_p[c]   = (m_pos[c] == 0);
        e_n[c]   = (m_pos[c] == hi);
        e_clk[c] = (m_pos[c] < hi);
        if (m_pos[c] != 0) all_start = 1'b0;
        if (m_pos[c] + 1 >= m_per[c]) begin
          m_pos[c] = 0;
          m_per[c] = int'(div[c*W +: W]) + 1;
        end else begin
          m_pos[c] = m_pos[c] + 1;
        end
      end
      e_al = all_start;
    end else begin
      e_p = '0; e_n = '0; e_al = 1'b0;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("cen_p", 32'(cen_p), 32'(e_p));
    chk("cen_n", 32'(cen_n), 32'(e_n));
    chk("clk_o", 32'(clk_o), 32'(e_clk));
    chk("aligned", 32'(aligned), 32'(e_al));
  endtask

  task automatic do_reset();
    reset = 1'b1; sync = 1'b0; en = 1'b1;
    step();
    step();
    chk("rst_zero", {25'd0, cen_p, cen_n, clk_o, aligned}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic scen1();
    for (int c = 1; c <= 10; c++) begin
      step();
      chk("s1_p0", 32'(cen_p[0]), 32'(c inside {1, 5, 9}));
      chk("s1_n0", 32'(cen_n[0]), 32'(c inside {3, 7}));
      chk("s1_clk0", 32'(clk_o[0]), 32'(c inside {1, 2, 5, 6, 9, 10}));
      chk("s1_p1", 32'(cen_p[1]), 32'(c % 2 == 1));
      chk("s1_al", 32'(aligned), 32'(c inside {1, 5, 9}));
    end
  endtask

  initial begin
    // Basic run: ratios 4 and 2, zero phase.
    set_div(0, 3); set_div(1, 1); set_ph(0, 0); set_ph(1, 0);
    do_reset();
    scen1();

    // Ratio change mid-period: old period completes, then period 6.
    do_reset();
    for (int c = 1; c <= 18; c++) begin
      if (c == 2) set_div(0, 5);
      step();
      chk("rc_p0", 32'(cen_p[0]), 32'(c inside {1, 5, 11, 17}));
      chk("rc_n0", 32'(cen_n[0]), 32'(c inside {3, 8, 14}));
    end

    // Pause: en low for three cycles shifts the next period start to 8.
    set_div(0, 3);
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      en = !(c inside {2, 3, 4});
      step();
      chk("pz_p0", 32'(cen_p[0]), 32'(c inside {1, 8}));
      chk("pz_n0", 32'(cen_n[0]), 32'(c == 6));
      chk("pz_clk0", 32'(clk_o[0]), 32'(c inside {1, 2, 3, 4, 5, 8, 9}));
    end
    en = 1'b1;

    // Sync with phase offset on channel 1.
    set_div(0, 3); set_div(1, 3); set_ph(1, 0);
    do_reset();
    for (int c = 1; c <= 18; c++) begin
      if (c == 11) begin
        set_ph(1, 2);
        sync = 1'b1;
      end else begin
        sync = 1'b0;
      end
      step();
      if (c == 11) chk("sy_zero", {28'd0, cen_p, cen_n}, 32'd0);
      if (c >= 11) begin
        chk("sy_p0", 32'(cen_p[0]), 32'(c inside {12, 16}));
        chk("sy_p1", 32'(cen_p[1]), 32'(c inside {14, 18}));
        chk("sy_al", 32'(aligned), 32'd0);
      end
    end
    // Back-to-back sync: counters held, no pulses.
    sync = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("sy_hold", {28'd0, cen_p, cen_n}, 32'd0);
    end
    sync = 1'b0;
    step();
    chk("sy_after_p0", 32'(cen_p[0]), 32'd1);
    chk("sy_after_p1", 32'(cen_p[1]), 32'd0);

    // Ratio 1: every cycle is both edges, level clock stays low.
    set_div(0, 0); set_ph(0, 0); set_ph(1, 0); set_div(1, 1);
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("r1_p0", 32'(cen_p[0]), 32'd1);
      chk("r1_n0", 32'(cen_n[0]), 32'd1);
      chk("r1_clk0", 32'(clk_o[0]), 32'd0);
    end

    // Out-of-range phase clamps to zero.
    set_div(0, 3); set_ph(0, 7);
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      step();
      chk("cl_p0", 32'(cen_p[0]), 32'(c inside {1, 5}));
    end

    // Reset mid-period, then the basic sequence must replay exactly.
    set_ph(0, 0); set_div(0, 3); set_div(1, 1);
    do_reset();
    step();
    step();
    reset = 1'b1;
    step();
    chk("mr_zero", {25'd0, cen_p, cen_n, clk_o, aligned}, 32'd0);
    reset = 1'b0;
    scen1();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      sync  = ($urandom_range(0, 79) == 0);
      en    = ($urandom_range(0, 7) != 0);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 31) == 0) begin
          case ($urandom_range(0, 5))
            0:       set_div(c, 255);
            1:       set_div(c, $urandom_range(0, 255));
            default: set_div(c, $urandom_range(0, 9));
          endcase
        end
        if ($urandom_range(0, 31) == 0) set_ph(c, $urandom_range(0, 15));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
